// File: rtl/stm_step_limiter_if.sv
// Beat stream into and out of stm_step_limiter: target intensity/phase in,
// slew-limited intensity/phase out with the transducer index of each output beat.
interface stm_step_limiter_if;
   logic [7:0] INTENSITY_IN;
   logic [7:0] PHASE_IN;
   logic       DIN_VALID;
   logic [7:0] INTENSITY_OUT;
   logic [7:0] PHASE_OUT;
   logic       DOUT_VALID;
   logic [7:0] DEBUG_IDX;

   modport master (
      output INTENSITY_IN, PHASE_IN, DIN_VALID,
      input  INTENSITY_OUT, PHASE_OUT, DOUT_VALID, DEBUG_IDX
   );

   modport slave (
      input  INTENSITY_IN, PHASE_IN, DIN_VALID,
      output INTENSITY_OUT, PHASE_OUT, DOUT_VALID, DEBUG_IDX
   );
endinterface

// File: rtl/stm_step_limiter.sv
// Per-transducer intensity/phase slew limiter with a DEPTH-entry previous-value RAM.
// Optional STM_STEP_LIMITER_STAT_EN adds CLAMP_CNT, a saturating count of clamped output beats.
module stm_step_limiter #(
   parameter int unsigned DEPTH = 249
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [7:0]        STEP_INTENSITY,
   input  logic [7:0]        STEP_PHASE,
   stm_step_limiter_if.slave io,
   output logic              BUSY
`ifdef STM_STEP_LIMITER_STAT_EN
   ,
   output logic [15:0]       CLAMP_CNT
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned IW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_STREAM
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   clr_addr_q, clr_addr_d;
   logic            busy_q, busy_d;
   logic [7:0]      step_int_q, step_int_d;
   logic [7:0]      step_ph_q, step_ph_d;
   logic            accept;
   logic [AW-1:0]   acc_idx;

   logic            s1_vld_q, s2_vld_q;
   logic [AW-1:0]   s1_idx_q, s2_idx_q;
   logic [7:0]      s1_int_q, s2_int_q;
   logic [7:0]      s1_ph_q, s2_ph_q;

   logic            out_vld_q;
   logic [7:0]      out_int_q, out_ph_q, out_idx_q;

   logic [15:0]     mem [DEPTH];
   logic [15:0]     rd_q;
   logic            mem_we;
   logic [AW-1:0]   mem_wa;
   logic [15:0]     mem_wd;

   logic [7:0]      cur_int, cur_ph;
   logic            int_up, int_clamp;
   logic [7:0]      int_mag, lim_int;
   logic [7:0]      ph_diff, ph_mag, lim_ph;
   logic            ph_neg, ph_clamp;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_CLEAR;
         idx_q      <= '0;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
         step_int_q <= '0;
         step_ph_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         clr_addr_q <= clr_addr_d;
         busy_q     <= busy_d;
         step_int_q <= step_int_d;
         step_ph_q  <= step_ph_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      clr_addr_d = clr_addr_q;
      busy_d     = busy_q;
      step_int_d = step_int_q;
      step_ph_d  = step_ph_q;
      accept     = 1'b0;
      acc_idx    = AW'(idx_q);
      case (state_q)
         S_CLEAR: begin
            if (clr_addr_q == AW'(DEPTH - 1)) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (io.DIN_VALID) begin
               step_int_d = STEP_INTENSITY;
               step_ph_d  = STEP_PHASE;
               accept     = 1'b1;
               acc_idx    = '0;
               idx_d      = IW'(1);
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            if (!io.DIN_VALID) begin
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (idx_q < IW'(DEPTH)) begin
               // Index saturates at DEPTH so overlong bursts are dropped until DIN_VALID falls.
               accept = 1'b1;
               idx_d  = idx_q + 1'b1;
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_vld_q  <= 1'b0;
         s1_idx_q  <= '0;
         s1_int_q  <= '0;
         s1_ph_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_idx_q  <= '0;
         s2_int_q  <= '0;
         s2_ph_q   <= '0;
         out_vld_q <= 1'b0;
         out_int_q <= '0;
         out_ph_q  <= '0;
         out_idx_q <= '0;
      end else begin
         s1_vld_q  <= accept;
         s1_idx_q  <= acc_idx;
         s1_int_q  <= io.INTENSITY_IN;
         s1_ph_q   <= io.PHASE_IN;
         s2_vld_q  <= s1_vld_q;
         s2_idx_q  <= s1_idx_q;
         s2_int_q  <= s1_int_q;
         s2_ph_q   <= s1_ph_q;
         out_vld_q <= s2_vld_q;
         if (s2_vld_q) begin
            out_int_q <= lim_int;
            out_ph_q  <= lim_ph;
            out_idx_q <= 8'(s2_idx_q);
         end
      end
   end

   // Write-back of beat i lands well before the next frame reads i (DEPTH >= 3), so no bypass.
   assign mem_we = (state_q == S_CLEAR) || s2_vld_q;
   assign mem_wa = (state_q == S_CLEAR) ? clr_addr_q : s2_idx_q;
   assign mem_wd = (state_q == S_CLEAR) ? 16'h0000 : {lim_int, lim_ph};

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
      rd_q <= mem[s1_idx_q];
   end

   assign {cur_int, cur_ph} = rd_q;

   always_comb begin
      int_up    = (s2_int_q >= cur_int);
      int_mag   = int_up ? (s2_int_q - cur_int) : (cur_int - s2_int_q);
      int_clamp = (int_mag > step_int_q);
      lim_int   = s2_int_q;
      if (int_clamp) begin
         lim_int = int_up ? (cur_int + step_int_q) : (cur_int - step_int_q);
      end

      // 0x80 is treated as +128 so the half-turn case always moves upward.
      ph_diff  = s2_ph_q - cur_ph;
      ph_neg   = ph_diff[7] && (ph_diff != 8'h80);
      ph_mag   = ph_neg ? (8'h00 - ph_diff) : ph_diff;
      ph_clamp = (ph_mag > step_ph_q);
      lim_ph   = s2_ph_q;
      if (ph_clamp) begin
         lim_ph = ph_neg ? (cur_ph - step_ph_q) : (cur_ph + step_ph_q);
      end
   end

`ifdef STM_STEP_LIMITER_STAT_EN
   logic [15:0] clamp_cnt_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         clamp_cnt_q <= '0;
      end else if (s2_vld_q && (int_clamp || ph_clamp) && (clamp_cnt_q != '1)) begin
         clamp_cnt_q <= clamp_cnt_q + 1'b1;
      end
   end

   assign CLAMP_CNT = clamp_cnt_q;
`endif

   assign io.INTENSITY_OUT = out_int_q;
   assign io.PHASE_OUT     = out_ph_q;
   assign io.DOUT_VALID    = out_vld_q;
   assign io.DEBUG_IDX     = out_idx_q;
   assign BUSY             = busy_q;

endmodule

// File: doc/stm_step_limiter.md
Name: stm_step_limiter

Overview:
- Per-transducer slew limiter directly downstream of the STM stage.
- Consumes the per-frame INTENSITY/PHASE stream (one beat per transducer, DEPTH beats per frame).
- Limits how far each transducer's value may move from its previous frame, using shortest-path wrap for phase.
- Emits the limited stream with fixed latency to the PWM stage. Previous values are held in an internal DEPTH-entry RAM.

Parameters:
- DEPTH, 249, transducers per frame; must be ≥ 3.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- STEP_INTENSITY  in  8  max intensity change per frame; 255 = unlimited
- STEP_PHASE  in  8  max phase change per frame, mod 256; 255 = unlimited
- INTENSITY_IN  in  8  target intensity
- PHASE_IN  in  8  target phase
- DIN_VALID  in  1  beat valid; high for a contiguous burst per frame
- INTENSITY_OUT  out  8  limited intensity
- PHASE_OUT  out  8  limited phase
- DOUT_VALID  out  1  output beat valid
- DEBUG_IDX  out  8  transducer index of the current output beat
- BUSY  out  1  high while the state RAM is being cleared

Behaviour:
- Reset values: all outputs 0 except BUSY, which is 1. FSM enters CLEAR; index counter is 0; latched steps are 0.
- FSM states:
  - CLEAR: writes 0 to every RAM address, 0..DEPTH-1, one per cycle. DIN_VALID is ignored and produces no output. Exits to IDLE after address DEPTH-1; BUSY falls on that same edge.
  - IDLE: on DIN_VALID=1, latch STEP_INTENSITY/STEP_PHASE, process the beat as index 0, go to STREAM.
  - STREAM: each DIN_VALID=1 beat increments the index. DIN_VALID=0 returns to IDLE and resets the index to 0. Beats with index ≥ DEPTH are dropped (no DOUT_VALID, no RAM write) until DIN_VALID falls.
- Step values are sampled only on the first beat of a burst. Mid-burst changes take effect on the next frame.
- Pipeline, 2 cycles: beat at edge t → RAM read at t+1, compute, registered output plus RAM write-back at t+2. DOUT_VALID is a 2-cycle delayed copy of accepted beats; DEBUG_IDX travels with its beat.
- Intensity rule, unsigned, no wrap, cur = stored value:
  - if |in−cur| ≤ step: out = in
  - else: out = cur ± step, moving toward in.
- Phase rule: d = (in−cur) mod 256, interpreted as signed 8-bit (−128..127).
  - if |d| ≤ step: out = in
  - else: out = (cur + sign(d)·step) mod 256
  - d = −128 (0x80) moves in the positive direction.
- Step 255 passes values through unchanged. Step 0 freezes the value.
- Output values are written back as the new cur for that index.
- Back-to-back bursts (1-cycle DIN_VALID gap) need no forwarding, because DEPTH ≥ 3 guarantees no read/write collision on one address.
- RST_N asserted mid-frame: pipeline and outputs clear asynchronously. CLEAR reruns, and any in-flight frame is lost.

Optional Feature:
- Macro STM_STEP_LIMITER_STAT_EN.
- When defined: adds output CLAMP_CNT (16 bits). It counts output beats in which intensity or phase was clamped (either one, counted once per beat). It saturates at 0xFFFF and is cleared by reset only.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release: BUSY=1 for exactly DEPTH cycles, then 0. DIN_VALID during CLEAR → no DOUT_VALID.
- Steps 255/255, one frame of random values → outputs equal inputs, 2-cycle latency, DEBUG_IDX 0..248.
- STEP_INTENSITY=10, all intensity targets 100 from state 0 → frames output 10, 20, …, 100, then hold 100.
- STEP_PHASE=16, cur=250, target=10 (d=+16) → 10. Target 40 from cur 250 (d=+46) → 10 (wraps up). Target 200 from cur 250 (d=−50) → 234.
- Phase d=0x80 with step 16 (cur=0, target=128) → 16. STEP_PHASE changed mid-burst → applies only from next frame.
- Burst of DEPTH+5 beats → exactly DEPTH output beats. Assert RST_N low mid-frame → outputs 0, BUSY=1, and after CLEAR the next frame starts from state 0.
